// File: rtl/fac8_seq_ctrl.sv
// Sequencer for the radix-8 twiddle multiplier stage (fac8_1).
// Tracks the beat position inside each FFT frame, drives the multiplier's twiddle
// select alongside the input beat, and delays valid/sof/eof to match the
// multiplier's registered output. Also counts frames and flags alignment errors.
module fac8_seq_ctrl #(
    parameter int unsigned BEATS_PER_FRAME = 32,
    parameter int unsigned SEL_SHIFT       = 2,
    parameter int unsigned LAT             = 1,
    parameter int unsigned FCNT_W          = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [2:0]        sel,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              sync_err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(BEATS_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
    logic [CNT_W-1:0]  beat_idx;
    logic [FCNT_W-1:0] frame_cnt_nxt;
    logic              sync_err_nxt;
    logic              accept;
    logic              tag_sof;
    logic              tag_eof;

    // Delay pipe, index 0 is the input side, LAT-1 the tail seen on the outputs.
    logic [LAT-1:0]    pipe_v;
    logic [LAT-1:0]    pipe_sof;
    logic [LAT-1:0]    pipe_eof;

    // Next-state: beat acceptance, frame position, frame count and sticky error.
    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        frame_cnt_nxt = frame_cnt;
        sync_err_nxt  = sync_err;
        accept        = 1'b0;
        // Position of the beat on the inputs this cycle; 0 whenever idle.
        beat_idx      = (state == RUN) ? beat_cnt : '0;

        unique case (state)
            IDLE: begin
                if (in_valid && en) begin
                    if (in_sof) begin
                        accept = 1'b1;
                    end else begin
                        sync_err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_sof) begin
                        // A sof always restarts the frame, even mid-frame.
                        beat_idx = '0;
                        if (beat_cnt != '0) begin
                            sync_err_nxt = 1'b1;
                        end
                    end else if (beat_cnt == '0) begin
                        sync_err_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        tag_sof = accept && (beat_idx == '0);
        tag_eof = accept && (beat_idx == LAST_BEAT);

        if (accept) begin
            if (tag_eof) begin
                beat_cnt_nxt  = '0;
                frame_cnt_nxt = frame_cnt + 1'b1;
                // en is only honoured at a frame boundary, so frames never truncate.
                state_nxt     = en ? RUN : IDLE;
            end else begin
                beat_cnt_nxt  = beat_idx + 1'b1;
                state_nxt     = RUN;
            end
        end
    end

    // Twiddle select follows the current beat position; the resync override keeps
    // a mid-frame sof beat on twiddle group 0.
    always_comb begin
        sel = beat_idx[SEL_SHIFT+2:SEL_SHIFT];
    end

    // Control state register with async reset and synchronous soft clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            sync_err  <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            frame_cnt <= '0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            frame_cnt <= frame_cnt_nxt;
            sync_err  <= sync_err_nxt;
        end
    end

    // Marker delay pipe; advances every cycle and inserts bubbles for idle cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_v   <= '0;
            pipe_sof <= '0;
            pipe_eof <= '0;
        end else if (clr) begin
            pipe_v   <= '0;
            pipe_sof <= '0;
            pipe_eof <= '0;
        end else begin
            pipe_v[0]   <= accept;
            pipe_sof[0] <= tag_sof;
            pipe_eof[0] <= tag_eof;
            for (int i = 1; i < int'(LAT); i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_sof[i] <= pipe_sof[i-1];
                pipe_eof[i] <= pipe_eof[i-1];
            end
        end
    end

    assign out_valid = pipe_v[LAT-1];
    assign out_sof   = pipe_sof[LAT-1];
    assign out_eof   = pipe_eof[LAT-1];
    assign busy      = (state == RUN);

endmodule

// File: tb/tb_fac8_seq_ctrl.sv
// Scoreboard bench for fac8_seq_ctrl: the driver pushes expected output markers,
// a monitor pops and compares them whenever out_valid is seen.
module tb_fac8_seq_ctrl;

    localparam int BPF = 32;
    localparam int LAT = 1;
    localparam int FW  = 4;  // narrow counter so the wrap case stays short

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [2:0]    sel;
    logic          out_valid;
    logic          out_sof;
    logic          out_eof;
    logic [FW-1:0] frame_cnt;
    logic          sync_err;
    logic          busy;

    fac8_seq_ctrl #(
        .BEATS_PER_FRAME (BPF),
        .SEL_SHIFT       (2),
        .LAT             (LAT),
        .FCNT_W          (FW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .sel       (sel),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .frame_cnt (frame_cnt),
        .sync_err  (sync_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   t;
        logic sof;
        logic eof;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: flag overdue expectations, then match any presented output beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].t < cyc) begin
                e = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing output: out_valid absent, expected at cycle %0d", e.t);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected output: out_valid=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("out cycle", cyc, e.t);
                    check("out_sof", out_sof, e.sof);
                    check("out_eof", out_eof, e.eof);
                end
            end
        end
    end

    // Drive one cycle; check sel for valid beats and queue the expected output.
    task automatic beat(input logic v, input logic s, input logic e, input logic [2:0] xsel,
                        input logic acc, input logic xsof, input logic xeof);
        @(negedge clk);
        en       = e;
        in_valid = v;
        in_sof   = s;
        #1;
        if (v) check("sel", sel, xsel);
        if (acc) sb.push_back('{t: cyc + LAT, sof: xsof, eof: xeof});
    endtask

    task automatic gap(input logic e);
        beat(1'b0, 1'b0, e, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One full frame; en drops from beat drop_at onward, gaps inserted when asked.
    task automatic frame(input bit gaps, input int drop_at);
        for (int i = 0; i < BPF; i++) begin
            if (gaps && i > 0) gap(1'b1);
            beat(1'b1, i == 0, i < drop_at, 3'(i / 4), 1'b1, i == 0, i == BPF - 1);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst sel", sel, 0);
        check("rst out_valid", out_valid, 0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst sync_err", sync_err, 0);
        check("rst busy", busy, 0);
        rstn = 1'b1;

        // Back-to-back frame
        frame(1'b0, 99);
        repeat (3) gap(1'b1);
        check("t1 frame_cnt", frame_cnt, 1);
        check("t1 sync_err", sync_err, 0);
        check("t1 busy", busy, 1);

        // Gapped frame
        frame(1'b1, 99);
        repeat (3) gap(1'b1);
        check("t2 frame_cnt", frame_cnt, 2);
        check("t2 sync_err", sync_err, 0);

        // en dropped at beat 10: frame still completes, then idle
        frame(1'b0, 10);
        repeat (3) gap(1'b0);
        check("t3 busy", busy, 0);
        check("t3 frame_cnt", frame_cnt, 3);
        beat(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) gap(1'b0);
        check("t3 busy after dropped sof", busy, 0);
        check("t3 sync_err", sync_err, 0);

        // Spurious sof at beat 17 resyncs the frame
        for (int i = 0; i < 17; i++) beat(1'b1, i == 0, 1'b1, 3'(i / 4), 1'b1, i == 0, 1'b0);
        beat(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < BPF; i++)
            beat(1'b1, 1'b0, 1'b1, 3'(i / 4), 1'b1, 1'b0, i == BPF - 1);
        repeat (3) gap(1'b1);
        check("t4 sync_err", sync_err, 1);
        check("t4 frame_cnt", frame_cnt, 4);
        check("t4 busy", busy, 1);

        // clr at beat 5 with in_valid high
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, 1'b1, 3'(i / 4), 1'b1, i == 0, 1'b0);
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; in_sof = 1'b0; clr = 1'b1;
        #1;
        check("t5 sel at beat 5", sel, 1);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        #1;
        check("t5 busy", busy, 0);
        check("t5 sel", sel, 0);
        check("t5 frame_cnt", frame_cnt, 0);
        check("t5 sync_err", sync_err, 0);
        check("t5 out_valid", out_valid, 0);

        // Idle beat without sof while enabled: dropped, error flagged
        beat(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) gap(1'b1);
        check("t6 sync_err", sync_err, 1);
        check("t6 busy", busy, 0);

        // 2^FW + 1 frames wrap the counter to 1
        for (int f = 0; f < (1 << FW) + 1; f++) frame(1'b0, 99);
        repeat (3) gap(1'b1);
        check("t7 frame_cnt wrap", frame_cnt, 1);

        // Beat 0 without sof in RUN is still tagged sof; then async reset mid-frame
        beat(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) beat(1'b1, 1'b0, 1'b1, 3'(i / 4), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        check("t8 busy before rstn", busy, 1);
        rstn = 1'b0;
        #1;
        check("t8 busy", busy, 0);
        check("t8 out_valid", out_valid, 0);
        check("t8 frame_cnt", frame_cnt, 0);
        check("t8 sync_err", sync_err, 0);
        check("t8 sel", sel, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) gap(1'b1);
        check("scoreboard drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
